// File: rtl/nbody_pkg.sv
// Shared types and constants for the n-body force scheduling datapath.
package nbody_pkg;

   localparam int ADDR_W = 15;
   localparam int DATA_W = 80;

   localparam logic [14:0] BODY_BASE_DEF  = 15'h000;
   localparam logic [14:0] FORCE_BASE_DEF = 15'h190;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_I,
      S_RD_J,
      S_ISSUE,
      S_WAIT_ACC,
      S_WRITE,
      S_DONE
   } sched_state_t;

endpackage

// File: rtl/force_pair_scheduler_lat.sv
// Read-latency timer: strobes once RD_LAT cycles after the read address
// first appears, then restarts for the next read.
module rd_lat_counter #(
   parameter int RD_LAT = 2
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_en,
   output logic o_valid
);

   localparam int CW = $clog2(RD_LAT + 1) + 1;

   logic [CW-1:0] r_cnt;

   assign o_valid = i_en && (r_cnt == CW'(RD_LAT));

   always_ff @(posedge i_clk) begin
      if (i_reset || !i_en || o_valid) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/force_pair_scheduler.sv
// Walks every ordered (target, source) body pair, feeds the force pipeline
// and writes each accumulated target force back to BRAM.
module force_pair_scheduler #(
   parameter int                N          = 2,
   parameter int                ADDR_W     = nbody_pkg::ADDR_W,
   parameter int                DATA_W     = nbody_pkg::DATA_W,
   parameter logic [ADDR_W-1:0] BODY_BASE  = nbody_pkg::BODY_BASE_DEF,
   parameter logic [ADDR_W-1:0] FORCE_BASE = nbody_pkg::FORCE_BASE_DEF,
   parameter int                RD_LAT     = 2
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   output logic              o_done,
   output logic [ADDR_W-1:0] o_rd_addr,
   input  logic [DATA_W-1:0] i_rd_data,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [DATA_W-1:0] o_wr_data,
   output logic              o_wren,
   output logic              o_pair_valid,
   input  logic              i_pair_ready,
   output logic [DATA_W-1:0] o_body_i,
   output logic [DATA_W-1:0] o_body_j,
   output logic              o_last_j,
   input  logic              i_acc_valid,
   input  logic [DATA_W-1:0] i_acc_data
);

   import nbody_pkg::*;

   localparam int            IW      = $clog2(N) + 1;
   localparam logic [IW-1:0] LAST_I  = IW'(N - 1);
   localparam logic [IW-1:0] J_FIRST = (N > 1) ? IW'(1) : '0;

   sched_state_t r_state, w_next;

   logic [IW-1:0]     r_i, r_j;
   logic [IW-1:0]     w_j_inc, w_j_next, w_last_idx;
   logic [DATA_W-1:0] r_body_i, r_body_j, r_acc;
   logic              w_rd_en, w_rd_vld, w_last_j;

   assign w_rd_en = (r_state == S_RD_I) || (r_state == S_RD_J);

   rd_lat_counter #(.RD_LAT(RD_LAT)) u_lat (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_en    (w_rd_en),
      .o_valid (w_rd_vld)
   );

   // The final source skips the target itself, so it is N-2 for the last target.
   assign w_last_idx = (r_i == LAST_I) ? IW'(N - 2) : LAST_I;
   assign w_last_j   = (r_j == w_last_idx);
   assign w_j_inc    = r_j + 1'b1;
   assign w_j_next   = (w_j_inc == r_i) ? w_j_inc + 1'b1 : w_j_inc;

   assign o_body_i = r_body_i;
   assign o_body_j = r_body_j;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next       = r_state;
      o_done       = 1'b0;
      o_rd_addr    = '0;
      o_wr_addr    = '0;
      o_wr_data    = '0;
      o_wren       = 1'b0;
      o_pair_valid = 1'b0;
      o_last_j     = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (i_start) w_next = S_RD_I;
         end
         S_RD_I: begin
            o_rd_addr = BODY_BASE + ADDR_W'(r_i);
            if (w_rd_vld) w_next = (N == 1) ? S_WRITE : S_RD_J;
         end
         S_RD_J: begin
            o_rd_addr = BODY_BASE + ADDR_W'(r_j);
            if (w_rd_vld) w_next = S_ISSUE;
         end
         S_ISSUE: begin
            o_pair_valid = 1'b1;
            o_last_j     = w_last_j;
            if (i_pair_ready) w_next = w_last_j ? S_WAIT_ACC : S_RD_J;
         end
         S_WAIT_ACC: begin
            if (i_acc_valid) w_next = S_WRITE;
         end
         S_WRITE: begin
            o_wren    = 1'b1;
            o_wr_addr = FORCE_BASE + ADDR_W'(r_i);
            o_wr_data = r_acc;
            w_next    = (r_i == LAST_I) ? S_DONE : S_RD_I;
         end
         S_DONE: begin
            o_done = 1'b1;
            if (i_start) w_next = S_RD_I;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_i      <= '0;
         r_j      <= '0;
         r_body_i <= '0;
         r_body_j <= '0;
         r_acc    <= '0;
      end else begin
         unique case (r_state)
            S_IDLE, S_DONE: begin
               if (i_start) begin
                  r_i <= '0;
                  r_j <= J_FIRST;
               end
            end
            S_RD_I: begin
               if (w_rd_vld) begin
                  r_body_i <= i_rd_data;
                  if (N == 1) r_acc <= '0;
               end
            end
            S_RD_J: begin
               if (w_rd_vld) r_body_j <= i_rd_data;
            end
            S_ISSUE: begin
               if (i_pair_ready && !w_last_j) r_j <= w_j_next;
            end
            S_WAIT_ACC: begin
               if (i_acc_valid) r_acc <= i_acc_data;
            end
            S_WRITE: begin
               // Source index 0 is never the target once i >= 1.
               if (r_i != LAST_I) begin
                  r_i <= r_i + 1'b1;
                  r_j <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_force_pair_scheduler.sv
// Directed bench for force_pair_scheduler with N=1, 2 and 3 instances
// sharing stimulus; one instance is observed per scenario.
module tb_force_pair_scheduler;

   localparam int AW = 15;
   localparam int DW = 80;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic pair_ready = 1'b0;
   logic acc_man = 1'b0;
   logic acc_auto = 1'b0;
   logic acc_valid;
   logic [DW-1:0] acc_data;

   logic [AW-1:0] rd_addr [1:3];
   logic [DW-1:0] rd_data [1:3];
   logic [AW-1:0] wa [1:3];
   logic [DW-1:0] wd [1:3];
   logic [DW-1:0] bi [1:3];
   logic [DW-1:0] bj [1:3];
   logic          done [1:3];
   logic          wren [1:3];
   logic          pv [1:3];
   logic          lj [1:3];
   logic [AW-1:0] p1 [1:3];
   logic [AW-1:0] p2 [1:3];

   int sel = 2;
   int acc_dly = 0;
   bit auto_en = 1'b0;
   int n_tests = 0;
   int n_fail = 0;

   logic [160:0] pq [$];
   logic [94:0]  wq [$];

   always #5 clk = ~clk;

   force_pair_scheduler #(.N(1)) u_n1 (
      .i_clk(clk), .i_reset(reset), .i_start(start), .o_done(done[1]),
      .o_rd_addr(rd_addr[1]), .i_rd_data(rd_data[1]),
      .o_wr_addr(wa[1]), .o_wr_data(wd[1]), .o_wren(wren[1]),
      .o_pair_valid(pv[1]), .i_pair_ready(pair_ready),
      .o_body_i(bi[1]), .o_body_j(bj[1]), .o_last_j(lj[1]),
      .i_acc_valid(acc_valid), .i_acc_data(acc_data)
   );

   force_pair_scheduler #(.N(2)) u_n2 (
      .i_clk(clk), .i_reset(reset), .i_start(start), .o_done(done[2]),
      .o_rd_addr(rd_addr[2]), .i_rd_data(rd_data[2]),
      .o_wr_addr(wa[2]), .o_wr_data(wd[2]), .o_wren(wren[2]),
      .o_pair_valid(pv[2]), .i_pair_ready(pair_ready),
      .o_body_i(bi[2]), .o_body_j(bj[2]), .o_last_j(lj[2]),
      .i_acc_valid(acc_valid), .i_acc_data(acc_data)
   );

   force_pair_scheduler #(.N(3)) u_n3 (
      .i_clk(clk), .i_reset(reset), .i_start(start), .o_done(done[3]),
      .o_rd_addr(rd_addr[3]), .i_rd_data(rd_data[3]),
      .o_wr_addr(wa[3]), .o_wr_data(wd[3]), .o_wren(wren[3]),
      .o_pair_valid(pv[3]), .i_pair_ready(pair_ready),
      .o_body_i(bi[3]), .o_body_j(bj[3]), .o_last_j(lj[3]),
      .i_acc_valid(acc_valid), .i_acc_data(acc_data)
   );

   // Two-stage BRAM: body record at address a reads back as 80'hA000 + a.
   always @(posedge clk) begin
      for (int k = 1; k <= 3; k++) begin
         p1[k] <= rd_addr[k];
         p2[k] <= p1[k];
      end
   end

   always_comb begin
      for (int k = 1; k <= 3; k++) rd_data[k] = {65'h0, p2[k]} + 80'hA000;
   end

   // Force result for target i is its body record + 80'h50000.
   assign acc_data  = bi[sel] + 80'h50000;
   assign acc_valid = acc_auto | acc_man;

   always @(posedge clk) begin
      acc_auto <= 1'b0;
      if (reset) begin
         acc_dly <= 0;
      end else if (acc_dly != 0) begin
         acc_dly <= acc_dly - 1;
         if (acc_dly == 1) acc_auto <= 1'b1;
      end else if (auto_en && pv[sel] && pair_ready && lj[sel]) begin
         acc_dly <= 3;
      end
   end

   always @(posedge clk) begin
      if (pv[sel] && pair_ready) pq.push_back({bi[sel], bj[sel], lj[sel]});
      if (wren[sel]) wq.push_back({wa[sel], wd[sel]});
   end

   function automatic logic [DW-1:0] body(input int k);
      return 80'hA000 + DW'(k);
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      start = 1'b0;
      pair_ready = 1'b0;
      acc_man = 1'b0;
      auto_en = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      pq.delete();
      wq.delete();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int c = 0;
      while (done[sel] !== 1'b1 && c < budget) begin
         @(negedge clk);
         c++;
      end
   endtask

   task automatic test_reset();
      do_reset();
      for (int k = 1; k <= 3; k++) begin
         n_tests++;
         if ({done[k], wren[k], pv[k], lj[k], rd_addr[k], wa[k], wd[k],
              bi[k], bj[k]} !== '0) begin
            n_fail++;
            $display("FAIL reset_outs dut=%0d done=%b wren=%b pv=%b rd=%h bi=%h",
                     k, done[k], wren[k], pv[k], rd_addr[k], bi[k]);
         end
      end
   endtask

   task automatic test_n2_basic();
      logic [160:0] ep [2];
      logic [94:0]  ew [2];
      ep[0] = {body(0), body(1), 1'b1};
      ep[1] = {body(1), body(0), 1'b1};
      ew[0] = {15'h190, 80'h5A000};
      ew[1] = {15'h191, 80'h5A001};
      do_reset();
      sel = 2;
      pair_ready = 1'b1;
      auto_en = 1'b1;
      pulse_start();
      wait_done(400);
      n_tests++;
      if (done[2] !== 1'b1) begin
         n_fail++;
         $display("FAIL n2_done got=%b exp=1", done[2]);
      end
      n_tests++;
      if (pq.size() != 2 || wq.size() != 2) begin
         n_fail++;
         $display("FAIL n2_counts pairs=%0d writes=%0d exp=2/2", pq.size(), wq.size());
      end else begin
         for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (pq[k] !== ep[k]) begin
               n_fail++;
               $display("FAIL n2_pair%0d got=%h exp=%h", k, pq[k], ep[k]);
            end
            n_tests++;
            if (wq[k] !== ew[k]) begin
               n_fail++;
               $display("FAIL n2_write%0d got=%h exp=%h", k, wq[k], ew[k]);
            end
         end
      end
   endtask

   task automatic test_n3_stall();
      int ei [6] = '{0, 0, 1, 1, 2, 2};
      int ej [6] = '{1, 2, 0, 2, 0, 1};
      bit el [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [160:0] e;
      int c = 0;
      do_reset();
      sel = 3;
      auto_en = 1'b1;
      pulse_start();
      while (pv[3] !== 1'b1 && c < 50) begin
         @(negedge clk);
         c++;
      end
      for (int k = 0; k < 5; k++) begin
         n_tests++;
         if (pv[3] !== 1'b1 || bi[3] !== body(0) || bj[3] !== body(1)) begin
            n_fail++;
            $display("FAIL n3_stall%0d pv=%b bi=%h bj=%h exp=1/%h/%h",
                     k, pv[3], bi[3], bj[3], body(0), body(1));
         end
         @(negedge clk);
      end
      pair_ready = 1'b1;
      wait_done(800);
      n_tests++;
      if (pq.size() != 6 || wq.size() != 3) begin
         n_fail++;
         $display("FAIL n3_counts pairs=%0d writes=%0d exp=6/3", pq.size(), wq.size());
      end else begin
         for (int k = 0; k < 6; k++) begin
            e = {body(ei[k]), body(ej[k]), el[k]};
            n_tests++;
            if (pq[k] !== e) begin
               n_fail++;
               $display("FAIL n3_pair%0d got=%h exp=%h", k, pq[k], e);
            end
         end
         for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (wq[k] !== {15'h190 + 15'(k), 80'h5A000 + 80'(k)}) begin
               n_fail++;
               $display("FAIL n3_write%0d got=%h", k, wq[k]);
            end
         end
      end
   endtask

   task automatic test_n1();
      do_reset();
      sel = 1;
      pair_ready = 1'b1;
      pulse_start();
      wait_done(100);
      n_tests++;
      if (done[1] !== 1'b1 || pq.size() != 0 || wq.size() != 1) begin
         n_fail++;
         $display("FAIL n1_counts done=%b pairs=%0d writes=%0d exp=1/0/1",
                  done[1], pq.size(), wq.size());
      end else begin
         n_tests++;
         if (wq[0] !== {15'h190, 80'h0}) begin
            n_fail++;
            $display("FAIL n1_write got=%h exp=%h", wq[0], {15'h190, 80'h0});
         end
      end
   endtask

   task automatic test_reset_mid();
      int c = 0;
      do_reset();
      sel = 2;
      pair_ready = 1'b1;
      pulse_start();
      while (!(pv[2] === 1'b1 && lj[2] === 1'b1) && c < 50) begin
         @(negedge clk);
         c++;
      end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({done[2], wren[2], pv[2], lj[2], rd_addr[2], wa[2], wd[2],
           bi[2], bj[2]} !== '0) begin
         n_fail++;
         $display("FAIL mid_reset_outs done=%b wren=%b pv=%b bi=%h exp=0",
                  done[2], wren[2], pv[2], bi[2]);
      end
      reset = 1'b0;
      repeat (10) @(negedge clk);
      n_tests++;
      if (wq.size() != 0) begin
         n_fail++;
         $display("FAIL mid_reset_nowrite writes=%0d exp=0", wq.size());
      end
      pq.delete();
      wq.delete();
      auto_en = 1'b1;
      pulse_start();
      wait_done(400);
      n_tests++;
      if (done[2] !== 1'b1 || pq.size() != 2 || wq.size() != 2) begin
         n_fail++;
         $display("FAIL mid_reset_rerun done=%b pairs=%0d writes=%0d exp=1/2/2",
                  done[2], pq.size(), wq.size());
      end else begin
         n_tests++;
         if (wq[0] !== {15'h190, 80'h5A000} || wq[1] !== {15'h191, 80'h5A001}) begin
            n_fail++;
            $display("FAIL mid_reset_writes got=%h %h", wq[0], wq[1]);
         end
      end
   endtask

   task automatic test_ignored_inputs();
      int c = 0;
      do_reset();
      sel = 2;
      auto_en = 1'b1;
      pulse_start();
      while (rd_addr[2] !== 15'h001 && c < 50) begin
         @(negedge clk);
         c++;
      end
      acc_man = 1'b1;
      @(negedge clk);
      acc_man = 1'b0;
      c = 0;
      while (pv[2] !== 1'b1 && c < 50) begin
         @(negedge clk);
         c++;
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      pair_ready = 1'b1;
      wait_done(400);
      n_tests++;
      if (done[2] !== 1'b1 || pq.size() != 2 || wq.size() != 2) begin
         n_fail++;
         $display("FAIL ignore_counts done=%b pairs=%0d writes=%0d exp=1/2/2",
                  done[2], pq.size(), wq.size());
      end else begin
         n_tests++;
         if (pq[0] !== {body(0), body(1), 1'b1} || pq[1] !== {body(1), body(0), 1'b1}) begin
            n_fail++;
            $display("FAIL ignore_pairs got=%h %h", pq[0], pq[1]);
         end
         n_tests++;
         if (wq[0] !== {15'h190, 80'h5A000} || wq[1] !== {15'h191, 80'h5A001}) begin
            n_fail++;
            $display("FAIL ignore_writes got=%h %h", wq[0], wq[1]);
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      sel = 2;
      pair_ready = 1'b1;
      auto_en = 1'b1;
      pulse_start();
      wait_done(400);
      pulse_start();
      n_tests++;
      if (done[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_done_fall got=%b exp=0", done[2]);
      end
      wait_done(400);
      n_tests++;
      if (done[2] !== 1'b1 || wq.size() != 4) begin
         n_fail++;
         $display("FAIL b2b_counts done=%b writes=%0d exp=1/4", done[2], wq.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (wq[k] !== {15'h190 + 15'(k % 2), 80'h5A000 + 80'(k % 2)}) begin
               n_fail++;
               $display("FAIL b2b_write%0d got=%h", k, wq[k]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_n2_basic();
      test_n3_stall();
      test_n1();
      test_reset_mid();
      test_ignored_inputs();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule
